// File: rtl/picoblaze_io_pkg.sv
// Shared PicoBlaze I/O definitions: port-ID map, IRQ controller FSM encoding
// and the priority helper used by the interrupt controller.
package picoblaze_io_pkg;

  // Port map shared with the top-level switch/LED decode
  localparam logic [7:0] SW_PORT       = 8'h00;
  localparam logic [7:0] LED_PORT      = 8'h01;
  localparam logic [7:0] IRQ_MASK_PORT = 8'h10;
  localparam logic [7:0] IRQ_PEND_PORT = 8'h11;
  localparam logic [7:0] IRQ_ID_PORT   = 8'h12;
  localparam logic [7:0] IRQ_EOI_PORT  = 8'h13;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef struct packed {
    logic       in_service;
    logic [3:0] zero;
    logic [2:0] cur_id;
  } irq_id_reg_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt source: 2-FF synchronizer followed by a history flop, giving a
// single-cycle pulse on each synchronized rising edge.
module irq_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~hist_q;

endmodule

// File: rtl/picoblaze_irq_ctrl.sv
// kcpsm6 interrupt controller: edge capture, masked pending set, lowest-index
// priority, IRQ handshake FSM and port-bus register file.
module picoblaze_irq_ctrl
  import picoblaze_io_pkg::*;
#(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] MASK_PORT = IRQ_MASK_PORT,
  parameter logic [7:0] PEND_PORT = IRQ_PEND_PORT,
  parameter logic [7:0] ID_PORT   = IRQ_ID_PORT,
  parameter logic [7:0] EOI_PORT  = IRQ_EOI_PORT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  output logic               interrupt,
  input  logic               interrupt_ack,
  output logic [7:0]         rd_data,
  output logic               rd_hit,
  output logic [1:0]         dbg_state
);

  // Handshake: interrupt is a registered level raised in ASSERT; the core
  // answers with a one-cycle interrupt_ack, after which the service window
  // stays open until software writes EOI_PORT.

  logic [NUM_SRC-1:0] evt;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] clr_bits;
  logic [NUM_SRC-1:0] active;
  logic [7:0]         active8, mask8, pend8;
  logic [2:0]         winner;
  logic               any_active;
  logic [2:0]         cur_id_q, cur_id_d;
  logic [1:0]         state_q, state_d;
  logic               irq_q, irq_d;
  logic               wr_mask, wr_pend, wr_eoi;
  irq_id_reg_t        id_reg;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (src[g]),
      .pulse_o (evt[g])
    );
  end

  assign wr_mask = write_strobe && (port_id == MASK_PORT);
  assign wr_pend = write_strobe && (port_id == PEND_PORT);
  assign wr_eoi  = write_strobe && (port_id == EOI_PORT);

  // A fresh event is ORed in after the clear so it survives a same-cycle W1C.
  always_comb begin
    mask_d   = wr_mask ? out_port[NUM_SRC-1:0] : mask_q;
    clr_bits = wr_pend ? out_port[NUM_SRC-1:0] : '0;
    pend_d   = (pend_q & ~clr_bits) | evt;
  end

  assign active     = pend_q & mask_q;
  assign any_active = |active;

  always_comb begin
    active8 = '0;
    mask8   = '0;
    pend8   = '0;
    active8[NUM_SRC-1:0] = active;
    mask8[NUM_SRC-1:0]   = mask_q;
    pend8[NUM_SRC-1:0]   = pend_q;
  end

  assign winner = lowest_set(active8);

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    cur_id_d = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_active) begin
          state_d  = ST_ASSERT;
          irq_d    = 1'b1;
          cur_id_d = winner;
        end
      end
      ST_ASSERT: begin
        // Ack wins over a same-cycle withdrawal.
        if (interrupt_ack) begin
          state_d = ST_SERVICE;
          irq_d   = 1'b0;
        end else if (!any_active) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        irq_d = 1'b0;
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q   <= '0;
      pend_q   <= '0;
      cur_id_q <= '0;
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      state_q  <= state_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    id_reg.in_service = (state_q == ST_SERVICE);
    id_reg.zero       = '0;
    id_reg.cur_id     = cur_id_q;
  end

  // Read data is zero off-hit so the top level can OR it into in_port.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    case (port_id)
      MASK_PORT: begin
        rd_data = mask8;
        rd_hit  = 1'b1;
      end
      PEND_PORT: begin
        rd_data = pend8;
        rd_hit  = 1'b1;
      end
      ID_PORT: begin
        rd_data = id_reg;
        rd_hit  = 1'b1;
      end
      EOI_PORT: begin
        rd_hit  = 1'b1;
      end
      default: begin
        rd_data = '0;
        rd_hit  = 1'b0;
      end
    endcase
  end

  assign interrupt = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_picoblaze_irq_ctrl.sv
// Directed bench for picoblaze_irq_ctrl with a queued scoreboard and a
// negedge monitor that pops and compares each requested observation.
module tb_picoblaze_irq_ctrl;
  import picoblaze_io_pkg::*;

  localparam logic [1:0] K_RD  = 2'd0;
  localparam logic [1:0] K_IRQ = 2'd1;
  localparam logic [1:0] K_ST  = 2'd2;
  localparam logic [1:0] K_HIT = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [7:0] src;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] rd_data;
  logic       rd_hit;
  logic [1:0] dbg_state;

  picoblaze_irq_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .src           (src),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .rd_data       (rd_data),
    .rd_hit        (rd_hit),
    .dbg_state     (dbg_state)
  );

  // scoreboard
  logic [9:0] exp_q[$];
  string      name_q[$];
  logic       chk_valid;
  int         checks   = 0;
  int         failures = 0;
  logic [9:0] mon_e;
  string      mon_n;
  logic [7:0] mon_act;

  always @(negedge clk) begin
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: observation requested with no expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        case (mon_e[9:8])
          K_RD:    mon_act = rd_data;
          K_IRQ:   mon_act = {7'b0, interrupt};
          K_ST:    mon_act = {6'b0, dbg_state};
          default: mon_act = {7'b0, rd_hit};
        endcase
        if (mon_act !== mon_e[7:0]) begin
          failures++;
          $display("FAIL %s: got %02h expected %02h", mon_n, mon_act, mon_e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    out_port     = 8'h00;
  endtask

  task automatic ack();
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
  endtask

  task automatic observe(input logic [1:0] k, input logic [7:0] p,
                         input logic [7:0] v, input string n);
    exp_q.push_back({k, v});
    name_q.push_back(n);
    if (k == K_RD || k == K_HIT) port_id = p;
    chk_valid = 1'b1;
    @(negedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic chk_rd(input logic [7:0] p, input logic [7:0] v, input string n);
    observe(K_RD, p, v, n);
  endtask

  task automatic chk_irq(input logic v, input string n);
    observe(K_IRQ, 8'h00, {7'b0, v}, n);
  endtask

  task automatic chk_st(input logic [1:0] v, input string n);
    observe(K_ST, 8'h00, {6'b0, v}, n);
  endtask

  task automatic chk_hit(input logic [7:0] p, input logic v, input string n);
    observe(K_HIT, p, {7'b0, v}, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    src           = 8'h00;
    port_id       = 8'h00;
    out_port      = 8'h00;
    write_strobe  = 1'b0;
    interrupt_ack = 1'b0;
    chk_valid     = 1'b0;
    ticks(2);

    // reset state
    chk_irq(1'b0, "rst_irq");
    chk_st(ST_IDLE, "rst_state");
    chk_rd(IRQ_MASK_PORT, 8'h00, "rst_mask");
    chk_rd(IRQ_PEND_PORT, 8'h00, "rst_pend");
    chk_rd(IRQ_ID_PORT, 8'h00, "rst_id");
    reset_n = 1'b1;
    tick();

    // 1: single source, exact capture and assertion latency
    wr(IRQ_MASK_PORT, 8'h04);
    src = 8'h04;
    ticks(2);
    chk_rd(IRQ_PEND_PORT, 8'h00, "t1_pend_after_edge1");
    chk_irq(1'b0, "t1_irq_after_edge2");
    chk_irq(1'b1, "t1_irq_after_edge3");
    chk_rd(IRQ_PEND_PORT, 8'h04, "t1_pend");
    chk_st(ST_ASSERT, "t1_state_assert");
    src = 8'h00;
    ack();
    chk_irq(1'b0, "t1_irq_after_ack");
    chk_rd(IRQ_ID_PORT, 8'h82, "t1_id");
    chk_st(ST_SERVICE, "t1_state_service");
    wr(IRQ_PEND_PORT, 8'h04);
    wr(IRQ_EOI_PORT, 8'h00);

    // 2: simultaneous sources, lowest index first, re-arm after EOI
    wr(IRQ_MASK_PORT, 8'hFF);
    src = 8'h22;
    ticks(4);
    chk_irq(1'b1, "t2_irq");
    chk_rd(IRQ_ID_PORT, 8'h01, "t2_id_assert");
    chk_rd(IRQ_PEND_PORT, 8'h22, "t2_pend");
    src = 8'h00;
    ack();
    chk_rd(IRQ_ID_PORT, 8'h81, "t2_id_service");
    chk_irq(1'b0, "t2_irq_service");
    wr(IRQ_PEND_PORT, 8'h02);
    wr(IRQ_EOI_PORT, 8'h00);
    chk_irq(1'b0, "t2_irq_low_after_eoi");
    chk_irq(1'b1, "t2_irq_rearm");
    chk_rd(IRQ_ID_PORT, 8'h05, "t2_id_rearm");
    ack();
    chk_rd(IRQ_ID_PORT, 8'h85, "t2_id_service5");
    wr(IRQ_PEND_PORT, 8'h20);
    wr(IRQ_EOI_PORT, 8'h00);

    // 3: masked capture, then unmask
    wr(IRQ_MASK_PORT, 8'h00);
    src = 8'h08;
    ticks(4);
    src = 8'h00;
    chk_rd(IRQ_PEND_PORT, 8'h08, "t3_pend_masked");
    chk_irq(1'b0, "t3_irq_masked");
    chk_st(ST_IDLE, "t3_state_idle");
    wr(IRQ_MASK_PORT, 8'h08);
    chk_irq(1'b0, "t3_irq_at_mask_edge");
    chk_irq(1'b1, "t3_irq_after_unmask");
    ack();
    wr(IRQ_PEND_PORT, 8'h08);
    wr(IRQ_EOI_PORT, 8'h00);

    // 4: withdrawal by masking before ack
    wr(IRQ_MASK_PORT, 8'h01);
    src = 8'h01;
    ticks(4);
    src = 8'h00;
    chk_irq(1'b1, "t4_irq");
    chk_st(ST_ASSERT, "t4_state_assert");
    wr(IRQ_MASK_PORT, 8'h00);
    chk_irq(1'b1, "t4_irq_at_mask_edge");
    chk_irq(1'b0, "t4_irq_withdrawn");
    chk_st(ST_IDLE, "t4_state_idle");
    chk_rd(IRQ_PEND_PORT, 8'h01, "t4_pend_kept");

    // 5: W1C racing an event, level gives one event, EOI in IDLE
    src = 8'h10;
    ticks(2);
    wr(IRQ_PEND_PORT, 8'h10);
    chk_rd(IRQ_PEND_PORT, 8'h11, "t5_event_wins");
    wr(IRQ_PEND_PORT, 8'h01);
    chk_rd(IRQ_PEND_PORT, 8'h10, "t5_w1c_level_held");
    wr(IRQ_EOI_PORT, 8'h00);
    chk_st(ST_IDLE, "t5_eoi_idle");
    chk_irq(1'b0, "t5_irq");
    src = 8'h00;
    chk_hit(8'h20, 1'b0, "t5_hit_other");
    chk_rd(8'h20, 8'h00, "t5_rd_other");
    chk_hit(IRQ_EOI_PORT, 1'b1, "t5_hit_eoi");
    chk_rd(IRQ_EOI_PORT, 8'h00, "t5_rd_eoi");

    // 6: asynchronous reset during SERVICE
    wr(IRQ_MASK_PORT, 8'h10);
    tick();
    chk_irq(1'b1, "t6_irq");
    ack();
    chk_st(ST_SERVICE, "t6_state_service");
    tick();
    reset_n = 1'b0;
    chk_st(ST_IDLE, "t6_state_async_reset");
    chk_irq(1'b0, "t6_irq_reset");
    chk_rd(IRQ_MASK_PORT, 8'h00, "t6_mask_reset");
    chk_rd(IRQ_PEND_PORT, 8'h00, "t6_pend_reset");
    chk_rd(IRQ_ID_PORT, 8'h00, "t6_id_reset");
    reset_n = 1'b1;
    ticks(5);
    chk_irq(1'b0, "t6_irq_quiet");
    chk_st(ST_IDLE, "t6_state_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
